// File: rtl/alu_multiciclo.sv
// alu_multiciclo: multi-cycle ALU with single-cycle logic/arithmetic ops,
// an iterative unsigned shift-add multiplier and, when ALU_DIV_EN is
// defined, an iterative unsigned restoring divider. Requests use a
// start/ready handshake, and completion is signalled by a one-cycle done pulse.
module alu_multiciclo #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] operando_a,
  input  logic [WIDTH-1:0] operando_b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultado_hi,
  output logic             zero,
  output logic             overflow,
  output logic             invalido
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CW-1:0]    count;
  logic             accept;
  logic             iter_op;

  // Iterative working registers: hi holds the partial product / remainder,
  // lo holds the multiplier / dividend being shifted, b_r the latched operand B.
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH:0]   mul_sum;

  logic [WIDTH-1:0] sum_w;
  logic [WIDTH-1:0] diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_inv;

`ifdef ALU_DIV_EN
  logic             is_div;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_sub;
`endif

  assign ready  = (state != ITER);
  assign done   = (state == FIM);
  assign accept = start && ready;
  assign sum_w  = operando_a + operando_b;
  assign diff_w = operando_a - operando_b;

  // Decide whether the incoming code needs the iterative datapath.
  always_comb begin
    iter_op = (alu_control == 4'b1000);
`ifdef ALU_DIV_EN
    if (alu_control == 4'b1001) iter_op = 1'b1;
`endif
  end

  // State register and iteration counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      if (accept && iter_op) count <= CW'(WIDTH - 1);
      else if (state == ITER && count != '0) count <= count - 1'b1;
    end
  end

  // Next-state logic; FIM behaves like IDLE for a new accept.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, FIM: begin
        if (accept) next_state = iter_op ? ITER : FIM;
        else        next_state = IDLE;
      end
      ITER: begin
        if (count == '0) next_state = FIM;
      end
      default: next_state = IDLE;
    endcase
  end

  // Single-cycle operations evaluated on the live inputs at accept.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_inv = 1'b0;
    case (alu_control)
      4'b0000: alu_res = operando_a & operando_b;
      4'b0001: alu_res = operando_a | operando_b;
      4'b0010: begin
        alu_res = sum_w;
        alu_ovf = (operando_a[WIDTH-1] == operando_b[WIDTH-1]) &&
                  (sum_w[WIDTH-1] != operando_a[WIDTH-1]);
      end
      4'b0110: begin
        alu_res = diff_w;
        alu_ovf = (operando_a[WIDTH-1] != operando_b[WIDTH-1]) &&
                  (diff_w[WIDTH-1] != operando_a[WIDTH-1]);
      end
      4'b0111: alu_res = ($signed(operando_a) < $signed(operando_b)) ? WIDTH'(1) : '0;
      4'b1100: alu_res = ~(operando_a | operando_b);
      default: alu_inv = 1'b1;
    endcase
  end

  // One iteration step of the multiplier (or divider when compiled in).
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
    // A zero divisor always "fits", so the quotient saturates to all ones
    // and the remainder ends up equal to the dividend without special casing.
    div_shift = {hi, lo[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, b_r});
    div_sub   = div_shift[WIDTH-1:0] - b_r;
    if (is_div) begin
      step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], div_ge};
    end
`endif
  end

  // Operand latching, iteration registers and registered results/flags.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi           <= '0;
      lo           <= '0;
      b_r          <= '0;
`ifdef ALU_DIV_EN
      is_div       <= 1'b0;
`endif
      resultado    <= '0;
      resultado_hi <= '0;
      zero         <= 1'b0;
      overflow     <= 1'b0;
      invalido     <= 1'b0;
    end else if (accept) begin
      if (iter_op) begin
        hi  <= '0;
        lo  <= operando_a;
        b_r <= operando_b;
`ifdef ALU_DIV_EN
        is_div <= alu_control[0];
`endif
      end else begin
        resultado    <= alu_res;
        resultado_hi <= '0;
        zero         <= (alu_res == '0);
        overflow     <= alu_ovf;
        invalido     <= alu_inv;
      end
    end else if (state == ITER) begin
      hi <= step_hi;
      lo <= step_lo;
      if (count == '0) begin
        resultado    <= step_lo;
        resultado_hi <= step_hi;
        zero         <= (step_lo == '0);
        overflow     <= 1'b0;
`ifdef ALU_DIV_EN
        invalido     <= is_div && (b_r == '0);
`else
        invalido     <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Directed self-checking bench for alu_multiciclo (WIDTH=32 and WIDTH=8).
module tb_alu_multiciclo;

  logic        clock = 1'b0;
  logic        reset;

  logic        s32, rdy32, dn32, z32, ov32, inv32;
  logic [3:0]  c32;
  logic [31:0] a32, b32, r32, rh32;

  logic        s8, rdy8, dn8, z8, ov8, inv8;
  logic [3:0]  c8;
  logic [7:0]  a8, b8, r8, rh8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  int lat;
  int pulses;

  alu_multiciclo #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(s32), .alu_control(c32),
    .operando_a(a32), .operando_b(b32), .ready(rdy32), .done(dn32),
    .resultado(r32), .resultado_hi(rh32), .zero(z32), .overflow(ov32),
    .invalido(inv32)
  );

  alu_multiciclo #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(s8), .alu_control(c8),
    .operando_a(a8), .operando_b(b8), .ready(rdy8), .done(dn8),
    .resultado(r8), .resultado_hi(rh8), .zero(z8), .overflow(ov8),
    .invalido(inv8)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is accepted on the following posedge.
  task automatic issue(input bit w8, input logic [3:0] c, input logic [63:0] a, input logic [63:0] b);
    if (w8) begin
      check("ready8_at_issue", {63'b0, rdy8}, 64'd1);
      s8 = 1'b1; c8 = c; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      check("ready32_at_issue", {63'b0, rdy32}, 64'd1);
      s32 = 1'b1; c32 = c; a32 = a[31:0]; b32 = b[31:0];
    end
    @(posedge clock);
    #1;
    s8 = 1'b0;
    s32 = 1'b0;
    t_acc = cyc;
  endtask

  // Waits (bounded) for done; latency 1 means done in the cycle after accept.
  task automatic wait_done(input bit w8, output int l);
    l = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if ((w8 ? dn8 : dn32) === 1'b1) begin
        l = cyc - t_acc + 1;
        break;
      end
    end
  endtask

  task automatic expect_op(input string name, input bit w8, input int lat_exp,
                           input logic [63:0] r, input logic [63:0] rh,
                           input logic z, input logic ov, input logic inv);
    int l;
    wait_done(w8, l);
    check($sformatf("%s.latency", name), 64'(l), 64'(lat_exp));
    if (w8) begin
      check($sformatf("%s.res", name), {56'b0, r8}, r);
      check($sformatf("%s.res_hi", name), {56'b0, rh8}, rh);
      check($sformatf("%s.flags", name), {61'b0, z8, ov8, inv8}, {61'b0, z, ov, inv});
    end else begin
      check($sformatf("%s.res", name), {32'b0, r32}, r);
      check($sformatf("%s.res_hi", name), {32'b0, rh32}, rh);
      check($sformatf("%s.flags", name), {61'b0, z32, ov32, inv32}, {61'b0, z, ov, inv});
    end
  endtask

  initial begin
    reset = 1'b1;
    s32 = 1'b0; c32 = '0; a32 = '0; b32 = '0;
    s8 = 1'b0;  c8 = '0;  a8 = '0;  b8 = '0;

    // Reset state
    @(negedge clock);
    check("rst.done", {63'b0, dn32}, 64'd0);
    check("rst.res", {32'b0, r32}, 64'd0);
    check("rst.flags", {61'b0, z32, ov32, inv32}, 64'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rst.ready", {63'b0, rdy32}, 64'd1);

    // ADD overflow, then SUB re-accepted in FIM
    issue(0, 4'b0010, 64'h7FFFFFFF, 64'h1);
    expect_op("add_ovf", 0, 1, 64'h80000000, 64'h0, 1'b0, 1'b1, 1'b0);
    check("fim.ready", {63'b0, rdy32}, 64'd1);
    issue(0, 4'b0110, 64'd5, 64'd5);
    expect_op("sub_zero", 0, 1, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);
    issue(0, 4'b0110, 64'h80000000, 64'h1);
    expect_op("sub_ovf", 0, 1, 64'h7FFFFFFF, 64'h0, 1'b0, 1'b1, 1'b0);

    // SLT signed
    issue(0, 4'b0111, 64'hFFFFFFFF, 64'h1);
    expect_op("slt_neg", 0, 1, 64'h1, 64'h0, 1'b0, 1'b0, 1'b0);
    issue(0, 4'b0111, 64'h1, 64'hFFFFFFFF);
    expect_op("slt_pos", 0, 1, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0);

    // Logic ops, WIDTH=32
    issue(0, 4'b0000, 64'hF0F0F0F0, 64'h0FF00FF0);
    expect_op("and32", 0, 1, 64'h00F000F0, 64'h0, 1'b0, 1'b0, 1'b0);
    issue(0, 4'b0001, 64'hF0F0F0F0, 64'h0FF00FF0);
    expect_op("or32", 0, 1, 64'hFFF0FFF0, 64'h0, 1'b0, 1'b0, 1'b0);
    issue(0, 4'b1100, 64'hF0F0F0F0, 64'h0FF00FF0);
    expect_op("nor32", 0, 1, 64'h000F000F, 64'h0, 1'b0, 1'b0, 1'b0);

    // MULU max operands, with a dropped start during ITER
    issue(0, 4'b1000, 64'hFFFFFFFF, 64'hFFFFFFFF);
    repeat (4) @(negedge clock);
    check("mul.ready_iter", {63'b0, rdy32}, 64'd0);
    s32 = 1'b1; c32 = 4'b0010; a32 = 32'd1; b32 = 32'd1;
    @(posedge clock);
    #1;
    s32 = 1'b0;
    expect_op("mulu_max", 0, 33, 64'h00000001, 64'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("mul.done_one_cycle", {63'b0, dn32}, 64'd0);
    check("mul.hold", {r32, rh32}, 64'hFFFFFFFE_00000001 >> 0 == 0 ? 64'h0 : {32'h00000001, 32'hFFFFFFFE});
    issue(0, 4'b1000, 64'd12345, 64'd678);
    expect_op("mulu_small", 0, 33, 64'd8369910, 64'h0, 1'b0, 1'b0, 1'b0);

`ifdef ALU_DIV_EN
    issue(0, 4'b1001, 64'd100, 64'd7);
    expect_op("divu", 0, 33, 64'd14, 64'd2, 1'b0, 1'b0, 1'b0);
    issue(0, 4'b1001, 64'd9, 64'd0);
    expect_op("divu_zero", 0, 33, 64'hFFFFFFFF, 64'd9, 1'b0, 1'b0, 1'b1);
`else
    issue(0, 4'b1001, 64'd100, 64'd7);
    expect_op("divu_absent", 0, 1, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);
`endif

    // Illegal code after a result with nonzero high word
    issue(0, 4'b1000, 64'hFFFFFFFF, 64'h2);
    expect_op("mulu_hi", 0, 33, 64'hFFFFFFFE, 64'h1, 1'b0, 1'b0, 1'b0);
    issue(0, 4'b0011, 64'h12345678, 64'h9ABCDEF0);
    expect_op("illegal", 0, 1, 64'h0, 64'h0, 1'b1, 1'b0, 1'b1);

    // Reset asserted mid-MULU
    issue(0, 4'b0010, 64'd1, 64'd2);
    expect_op("pre_rst_add", 0, 1, 64'd3, 64'h0, 1'b0, 1'b0, 1'b0);
    issue(0, 4'b1000, 64'hFFFFFFFF, 64'hFFFFFFFF);
    repeat (9) @(negedge clock);
    check("rst_mid.ready_before", {63'b0, rdy32}, 64'd0);
    #2 reset = 1'b1;
    #1;
    check("rst_mid.outputs", {r32, rh32}, 64'h0);
    check("rst_mid.flags_done", {60'b0, z32, ov32, inv32, dn32}, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid.ready_after", {63'b0, rdy32}, 64'd1);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (dn32 === 1'b1) pulses++;
    end
    check("rst_mid.no_late_done", 64'(pulses), 64'd0);

    // WIDTH=8 truncation
    issue(1, 4'b0000, 64'hF0, 64'h3C);
    expect_op("and8", 1, 1, 64'h30, 64'h0, 1'b0, 1'b0, 1'b0);
    issue(1, 4'b0001, 64'hF0, 64'h0F);
    expect_op("or8", 1, 1, 64'hFF, 64'h0, 1'b0, 1'b0, 1'b0);
    issue(1, 4'b1100, 64'hF0, 64'h0F);
    expect_op("nor8", 1, 1, 64'h00, 64'h0, 1'b1, 1'b0, 1'b0);
    issue(1, 4'b0010, 64'h80, 64'h80);
    expect_op("add8_wrap", 1, 1, 64'h00, 64'h0, 1'b1, 1'b1, 1'b0);
    issue(1, 4'b1000, 64'hFF, 64'hFF);
    expect_op("mulu8", 1, 9, 64'h01, 64'hFE, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
